mem_access_ctrl: RTL and testbench

Sequential load/store controller that sits directly upstream of the 16×8 data memory and is its only driver. Accepts single-word LOAD/STORE and multi-word FILL/COPY requests over a valid/ready handshake. Sequences the memory's level-sensitive write strobe so address and data are never changed while the strobe is high. Returns one response pulse per request.

---
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer and sole driver of a 16x8 memory with a level-sensitive write strobe.
// Handles LOAD, STORE, FILL and COPY requests and returns one response pulse per request.
module mem_access_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [3:0] req_addr,
    input  logic [3:0] req_addr2,
    input  logic [7:0] req_data,
    input  logic [4:0] req_count,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] mem_data_in,
    output logic [3:0] mem_write_select,
    output logic [3:0] mem_read_select,
    output logic       mem_select,
    input  logic [7:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        CP_RD,
        DONE
    } state_e;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b11;

    state_e     state_q;
    logic [1:0] op_q;
    logic [3:0] dst_q;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic [3:0] rsel_q;
    logic [3:0] wsel_q;
    logic [7:0] din_q;
    logic       sel_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       rsp_err_q;
    logic       busy_q;
    logic       count_bad;
    logic       last_word;

    assign count_bad = req_op[1] && ((req_count == 5'd0) || (req_count > 5'd16));
    assign last_word = (cnt_q == 5'd1);
    assign cnt_d     = cnt_q - 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            dst_q       <= 4'd0;
            cnt_q       <= 5'd0;
            rsel_q      <= 4'd0;
            wsel_q      <= 4'd0;
            din_q       <= 8'd0;
            sel_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        busy_q <= 1'b1;
                        op_q   <= req_op;
                        cnt_q  <= req_count;
                        if (count_bad) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            unique case (req_op)
                                OP_LOAD: begin
                                    state_q <= LD_RD;
                                    rsel_q  <= req_addr;
                                end
                                OP_COPY: begin
                                    state_q <= CP_RD;
                                    rsel_q  <= req_addr;
                                    dst_q   <= req_addr2;
                                end
                                default: begin
                                    state_q <= WR_SETUP;
                                    wsel_q  <= req_addr;
                                    din_q   <= req_data;
                                    if (req_op == OP_STORE) cnt_q <= 5'd1;
                                end
                            endcase
                        end
                    end
                end
                LD_RD: begin
                    rsp_data_q  <= mem_data_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                WR_SETUP: begin
                    sel_q   <= 1'b1;
                    state_q <= WR_STROBE;
                end
                WR_STROBE: begin
                    sel_q <= 1'b0;
                    cnt_q <= cnt_d;
                    // The cycle after the strobe is the hold; address/data stay put.
                    if (last_word) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (op_q == OP_COPY) begin
                        rsel_q  <= rsel_q + 4'd1;
                        state_q <= CP_RD;
                    end else begin
                        state_q <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    wsel_q  <= wsel_q + 4'd1;
                    state_q <= WR_SETUP;
                end
                CP_RD: begin
                    din_q   <= mem_data_out;
                    wsel_q  <= dst_q;
                    dst_q   <= dst_q + 4'd1;
                    state_q <= WR_SETUP;
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= 8'd0;
                    rsp_err_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready        = (state_q == IDLE) && rst_n;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_err          = rsp_err_q;
    assign busy             = busy_q;
    assign mem_data_in      = din_q;
    assign mem_write_select = wsel_q;
    assign mem_read_select  = rsel_q;
    assign mem_select       = sel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with an attached 16x8 memory model.
// Directed scenarios plus random requests against a behavioural reference.
module tb_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_addr;
    logic [3:0] req_addr2;
    logic [7:0] req_data;
    logic [4:0] req_count;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [7:0] mem_data_in;
    logic [3:0] mem_write_select;
    logic [3:0] mem_read_select;
    logic       mem_select;
    logic [7:0] mem_data_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_addr(req_addr),
        .req_addr2(req_addr2),
        .req_data(req_data),
        .req_count(req_count),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy),
        .mem_data_in(mem_data_in),
        .mem_write_select(mem_write_select),
        .mem_read_select(mem_read_select),
        .mem_select(mem_select),
        .mem_data_out(mem_data_out)
    );

    // Memory model: write while the strobe is high, combinational read.
    logic [7:0] mem [16] = '{default: 8'h00};
    always @(posedge clk) if (mem_select === 1'b1) mem[mem_write_select] <= mem_data_in;
    assign mem_data_out = mem[mem_read_select];

    // Strobe counter and write-port stability monitor.
    int strobes = 0;
    int viol = 0;
    logic       sel_p = 1'b0;
    logic       rst_p = 1'b0;
    logic [3:0] wsel_p = 4'd0;
    logic [7:0] din_p = 8'd0;
    always @(negedge clk) begin
        if (mem_select === 1'b1) strobes++;
        if (rst_n === 1'b1 && rst_p === 1'b1) begin
            if (mem_select === 1'b1 && sel_p === 1'b1) viol++;
            if ((sel_p === 1'b1 || mem_select === 1'b1) &&
                (mem_write_select !== wsel_p || mem_data_in !== din_p)) viol++;
        end
        sel_p  = mem_select;
        rst_p  = rst_n;
        wsel_p = mem_write_select;
        din_p  = mem_data_in;
    end

    logic [7:0] ref_mem [16] = '{default: 8'h00};

    function automatic bit bad_cnt(input logic [1:0] op, input int n);
        return op[1] && (n < 1 || n > 16);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input int n);
        if (bad_cnt(op, n)) return 1;
        case (op)
            2'b00:   return 2;
            2'b01:   return 3;
            2'b10:   return 3 * n;
            default: return 3 * n + 1;
        endcase
    endfunction

    function automatic int exp_str(input logic [1:0] op, input int n);
        if (bad_cnt(op, n)) return 0;
        case (op)
            2'b00:   return 0;
            2'b01:   return 1;
            default: return n;
        endcase
    endfunction

    // Applies a request to the reference memory; returns the LOAD result.
    function automatic logic [7:0] ref_exec(input logic [1:0] op, input logic [3:0] a,
                                            input logic [3:0] a2, input logic [7:0] d,
                                            input int n);
        logic [7:0] r = 8'h00;
        if (bad_cnt(op, n)) return 8'h00;
        case (op)
            2'b00: r = ref_mem[a];
            2'b01: ref_mem[a] = d;
            2'b10: for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 16] = d;
            default:
                for (int k = 0; k < n; k++)
                    ref_mem[(int'(a2) + k) % 16] = ref_mem[(int'(a) + k) % 16];
        endcase
        return r;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] a2,
                          input logic [7:0] d, input logic [4:0] n,
                          output int lat, output logic [7:0] rd, output logic re,
                          output int nstr, output logic rdy, output logic bsy);
        int s0;
        @(negedge clk);
        rdy = req_ready;
        s0 = strobes;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_addr2 = a2;
        req_data  = d;
        req_count = n;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = -1;
        rd  = 8'h00;
        re  = 1'b0;
        bsy = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) bsy = busy;
            if (rsp_valid === 1'b1) begin
                lat = c;
                rd  = rsp_data;
                re  = rsp_err;
                break;
            end
        end
        nstr = strobes - s0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_addr = 4'd0;
        req_addr2 = 4'd0;
        req_data = 8'd0;
        req_count = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        checks++;
        if ({busy, rsp_valid, rsp_err, mem_select} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, rsp_valid, rsp_err, mem_select});
        end
        checks++;
        if ({rsp_data, mem_data_in, mem_write_select, mem_read_select} !== 24'h0) begin
            failures++;
            $display("FAIL reset_buses got=%h exp=0",
                     {rsp_data, mem_data_in, mem_write_select, mem_read_select});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b%b exp=10", req_ready, busy);
        end
    endtask

    task automatic test_store_load;
        int lat, nstr;
        logic [7:0] rd, ex;
        logic re, rdy, bsy;
        ex = ref_exec(2'b01, 4'd7, 4'd0, 8'h55, 1);
        do_req(2'b01, 4'd7, 4'd0, 8'h55, 5'd1, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 3 || rd !== 8'h00 || re !== 1'b0) begin
            failures++;
            $display("FAIL store_rsp got=lat%0d/%h/%b exp=lat3/00/0", lat, rd, re);
        end
        checks++;
        if (nstr !== 1 || rdy !== 1'b1 || bsy !== 1'b1) begin
            failures++;
            $display("FAIL store_strobe got=%0d/%b/%b exp=1/1/1", nstr, rdy, bsy);
        end
        checks++;
        if (mem[7] !== 8'h55) begin
            failures++;
            $display("FAIL store_mem got=%h exp=55", mem[7]);
        end
        ex = ref_exec(2'b00, 4'd7, 4'd0, 8'h00, 0);
        do_req(2'b00, 4'd7, 4'd0, 8'h00, 5'd0, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 2 || rd !== 8'h55 || rd !== ex || re !== 1'b0) begin
            failures++;
            $display("FAIL load_rsp got=lat%0d/%h/%b exp=lat2/55/0", lat, rd, re);
        end
        checks++;
        if (nstr !== 0 || rdy !== 1'b1) begin
            failures++;
            $display("FAIL load_strobe got=%0d/%b exp=0/1", nstr, rdy);
        end
    endtask

    task automatic test_fill_wrap;
        int lat, nstr;
        logic [7:0] rd, ex;
        logic re, rdy, bsy;
        ex = ref_exec(2'b10, 4'd14, 4'd0, 8'hA5, 4);
        do_req(2'b10, 4'd14, 4'd0, 8'hA5, 5'd4, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 12 || nstr !== 4 || re !== 1'b0 || rd !== ex) begin
            failures++;
            $display("FAIL fill_rsp got=lat%0d/str%0d/%b exp=lat12/str4/0", lat, nstr, re);
        end
        checks++;
        if ({mem[14], mem[15], mem[0], mem[1]} !== 32'hA5A5A5A5 || mem[2] !== 8'h00) begin
            failures++;
            $display("FAIL fill_mem got=%h%h%h%h/%h exp=A5A5A5A5/00",
                     mem[14], mem[15], mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_copy_full;
        int lat, nstr, bad;
        logic [7:0] rd, ex;
        logic re, rdy, bsy;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            ex = ref_exec(2'b01, 4'(i), 4'd0, 8'(8'h10 + i), 1);
            do_req(2'b01, 4'(i), 4'd0, 8'(8'h10 + i), 5'd1, lat, rd, re, nstr, rdy, bsy);
            if (lat !== 3) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL copy_prep_lat got=%0d exp=0", bad);
        end
        ex = ref_exec(2'b11, 4'd0, 4'd8, 8'h00, 16);
        do_req(2'b11, 4'd0, 4'd8, 8'h00, 5'd16, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 49 || nstr !== 16 || re !== 1'b0 || rd !== 8'h00) begin
            failures++;
            $display("FAIL copy16_rsp got=lat%0d/str%0d/%b exp=lat49/str16/0", lat, nstr, re);
        end
        // Ascending copy re-reads words 8..15 after they were overwritten.
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== 8'(8'h10 + (i % 8))) begin
                failures++;
                $display("FAIL copy16_mem[%0d] got=%h exp=%h", i, mem[i], 8'(8'h10 + (i % 8)));
            end
        end
    endtask

    task automatic test_copy_overlap;
        int lat, nstr;
        logic [7:0] rd, ex;
        logic re, rdy, bsy;
        for (int i = 0; i < 4; i++) begin
            ex = ref_exec(2'b01, 4'(i), 4'd0, 8'(i + 1), 1);
            do_req(2'b01, 4'(i), 4'd0, 8'(i + 1), 5'd1, lat, rd, re, nstr, rdy, bsy);
        end
        ex = ref_exec(2'b11, 4'd0, 4'd1, 8'h00, 3);
        do_req(2'b11, 4'd0, 4'd1, 8'h00, 5'd3, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 10 || nstr !== 3) begin
            failures++;
            $display("FAIL overlap_rsp got=lat%0d/str%0d exp=lat10/str3", lat, nstr);
        end
        checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h01010101) begin
            failures++;
            $display("FAIL overlap_mem got=%h%h%h%h exp=01010101", mem[0], mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_errors;
        int lat, nstr, diff;
        logic [7:0] rd;
        logic re, rdy, bsy;
        logic [7:0] snap [16];
        snap = mem;
        do_req(2'b10, 4'd3, 4'd0, 8'hFF, 5'd0, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 1 || re !== 1'b1 || rd !== 8'h00 || nstr !== 0) begin
            failures++;
            $display("FAIL err_fill0 got=lat%0d/%b/%h/str%0d exp=lat1/1/00/str0", lat, re, rd, nstr);
        end
        do_req(2'b11, 4'd0, 4'd5, 8'hFF, 5'd17, lat, rd, re, nstr, rdy, bsy);
        checks++;
        if (lat !== 1 || re !== 1'b1 || rd !== 8'h00 || nstr !== 0 || rdy !== 1'b1) begin
            failures++;
            $display("FAIL err_copy17 got=lat%0d/%b/%h/str%0d exp=lat1/1/00/str0", lat, re, rd, nstr);
        end
        @(negedge clk);
        checks++;
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b%b exp=00", rsp_err, rsp_valid);
        end
        diff = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) diff++;
        checks++;
        if (diff !== 0) begin
            failures++;
            $display("FAIL err_mem got=%0d changed exp=0", diff);
        end
    endtask

    task automatic test_reset_mid_fill;
        int got, s0, diff;
        logic [7:0] snap [16];
        snap = mem;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 2'b10;
        req_addr = 4'd0;
        req_data = 8'h3C;
        req_count = 5'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (mem_select !== 1'b1 || mem_write_select !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_strobe got=%b/%0d exp=1/1", mem_select, mem_write_select);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mem_select !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_edge got=%b%b exp=00", mem_select, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got++;
        end
        checks++;
        if (got !== 0 || strobes !== s0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after got=rsp%0d/str%0d/%b exp=rsp0/str0/1",
                     got, strobes - s0, req_ready);
        end
        checks++;
        if (mem[0] !== 8'h3C || mem[1] !== 8'h3C) begin
            failures++;
            $display("FAIL rstmid_written got=%h%h exp=3C3C", mem[0], mem[1]);
        end
        diff = 0;
        for (int i = 3; i < 8; i++) if (mem[i] !== snap[i]) diff++;
        checks++;
        if (diff !== 0) begin
            failures++;
            $display("FAIL rstmid_untouched got=%0d changed exp=0", diff);
        end
        ref_mem[0] = 8'h3C;
        ref_mem[1] = 8'h3C;
    endtask

    task automatic test_random;
        int lat, nstr, n, elat, estr, diff;
        logic [1:0] op;
        logic [3:0] a, a2;
        logic [7:0] d, rd, ex;
        logic re, rdy, bsy;
        for (int t = 0; t < 60; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            a2 = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
            else n = $urandom_range(1, 16);
            elat = exp_lat(op, n);
            estr = exp_str(op, n);
            ex = ref_exec(op, a, a2, d, n);
            do_req(op, a, a2, d, 5'(n), lat, rd, re, nstr, rdy, bsy);
            checks++;
            if (lat !== elat || rd !== ex || re !== bad_cnt(op, n)) begin
                failures++;
                $display("FAIL rand%0d_rsp op=%0d n=%0d got=lat%0d/%h/%b exp=lat%0d/%h/%b",
                         t, op, n, lat, rd, re, elat, ex, bad_cnt(op, n));
            end
            checks++;
            if (nstr !== estr || rdy !== 1'b1 || bsy !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_seq got=str%0d/%b/%b exp=str%0d/1/1", t, nstr, rdy, bsy, estr);
            end
        end
        diff = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) diff++;
        checks++;
        if (diff !== 0) begin
            failures++;
            $display("FAIL rand_mem got=%0d words differ exp=0", diff);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_fill_wrap();
        test_copy_full();
        test_copy_overlap();
        test_errors();
        test_reset_mid_fill();
        test_random();
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL write_port_stability got=%0d exp=0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
